// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder.
// Build option: DMEM_CHECK_EN enables access-fault detection (see dmem_responder).
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // RISC-V load/store funct3 size encodings
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_D  = 3'b011;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;
  localparam logic [2:0] SZ_WU = 3'b110;

  // Byte-offset bits that must be zero for a naturally aligned access
  function automatic logic [2:0] align_bits(input logic [2:0] size);
    case (size[1:0])
      2'd0:    align_bits = 3'b000;
      2'd1:    align_bits = 3'b001;
      2'd2:    align_bits = 3'b011;
      default: align_bits = 3'b111;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] size, input logic [2:0] off);
    is_aligned = (off & align_bits(size)) == 3'b000;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data RAM: load extraction with sign/zero
// extension, and byte-masked merge of store data into a doubleword.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [2:0]  off_i,
  input  logic [63:0] dword_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] load_o,
  output logic [63:0] store_o
);

  logic [63:0] shifted;
  logic [63:0] wshift;
  logic [7:0]  width_mask;
  logic [7:0]  byte_mask;

  // Load path: shift addressed bytes down, then extend per size
  always_comb begin
    shifted = dword_i >> {off_i, 3'b000};
    case (size_i)
      SZ_B:    load_o = {{56{shifted[7]}}, shifted[7:0]};
      SZ_BU:   load_o = {56'd0, shifted[7:0]};
      SZ_H:    load_o = {{48{shifted[15]}}, shifted[15:0]};
      SZ_HU:   load_o = {48'd0, shifted[15:0]};
      SZ_W:    load_o = {{32{shifted[31]}}, shifted[31:0]};
      SZ_WU:   load_o = {32'd0, shifted[31:0]};
      SZ_D:    load_o = shifted;
      default: load_o = shifted;
    endcase
  end

  // Store path: place right-justified data at the offset and merge by byte mask
  always_comb begin
    case (size_i[1:0])
      2'd0:    width_mask = 8'h01;
      2'd1:    width_mask = 8'h03;
      2'd2:    width_mask = 8'h0F;
      default: width_mask = 8'hFF;
    endcase
    byte_mask = width_mask << off_i;
    wshift    = wdata_i << {off_i, 3'b000};
    store_o   = dword_i;
    for (int unsigned i = 0; i < 8; i++) begin
      if (byte_mask[i]) store_o[8*i +: 8] = wshift[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one outstanding request,
// LATENCY wait cycles, sized/extended load data or store acknowledge.
// Build option: DMEM_CHECK_EN reports misaligned, out-of-range and illegal
// store sizes on rsp_err; without it addresses wrap and are force-aligned.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_DW = 64,
  parameter int unsigned LATENCY  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW  = $clog2(DEPTH_DW);
  localparam logic [3:0]  LAT = 4'(LATENCY);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  size_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        err_q;
  logic [63:0] mem_q [DEPTH_DW] = '{default: '0};

  logic          accept;
  logic          access;
  logic          acc_we;
  logic [2:0]    acc_size;
  logic [63:0]   acc_addr;
  logic [63:0]   acc_wdata;
  logic [2:0]    acc_off;
  logic [AW-1:0] acc_idx;
  logic          acc_err;
  logic [63:0]   load_data;
  logic [63:0]   store_dword;

  assign accept = (state_q == IDLE) && req_valid;
  assign access = (state_d == RESP) && (state_q != RESP);

  // With LATENCY=0 the access happens on the accept edge, so it must use
  // the live request; otherwise the captured copy is used.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_size  = req_size;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_size  = size_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign acc_idx = acc_addr[3 +: AW];

`ifdef DMEM_CHECK_EN
  // Fault detection: misaligned, beyond RAM, or illegal store size
  always_comb begin
    acc_off = acc_addr[2:0];
    acc_err = !is_aligned(acc_size, acc_addr[2:0])
           || (|acc_addr[63:AW+3])
           || (acc_we && acc_size[2])
           || (acc_size == 3'b111);
  end
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^acc_addr[63:AW+3];

  // No faults: upper bits wrap, sub-size offset bits are forced to zero
  always_comb begin
    acc_off = acc_addr[2:0] & ~align_bits(acc_size);
    acc_err = 1'b0;
  end
`endif

  dmem_lane_align u_lane (
    .size_i  (acc_size),
    .off_i   (acc_off),
    .dword_i (mem_q[acc_idx]),
    .wdata_i (acc_wdata),
    .load_o  (load_data),
    .store_o (store_dword)
  );

  // State and wait-counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = (LAT == 4'd0) ? RESP : WAIT;
          cnt_d   = LAT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

  // Request capture and registered response data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (access) begin
        rdata_q <= (acc_we || acc_err) ? '0 : load_data;
        err_q   <= acc_err;
      end
    end
  end

  // RAM write; gated by reset so an aborted store never commits
  always_ff @(posedge clk) begin
    if (reset && access && acc_we && !acc_err) mem_q[acc_idx] <= store_dword;
  end

endmodule
